// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one unified memory bus between the instruction-fetch
//               (IF) port and the load/store (MEM) port of the pipeline.
//               Each transaction runs IDLE -> BUSY_x -> RESP. When both ports
//               are pending, the one not granted last time wins. Read data is
//               returned to the winning port and the pipeline stall is derived
//               from outstanding requests.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               if_req/if_addr      - fetch request (held until if_valid)
//               if_rdata/if_valid   - fetched word, one-cycle completion pulse
//               mem_req/mem_we/mem_addr/mem_wdata/mem_wmask - load/store request
//               mem_rdata/mem_valid - load data, one-cycle completion pulse
//               pipe_stall          - combinational pipeline stall
//               bus_req/bus_we/bus_addr/bus_wdata/bus_wmask - registered bus
//               bus_ack/bus_rdata   - slave completion and read data
//               timeout_err         - sticky bus-timeout flag
// Options     : MEM_PORT_ARBITER_TIMEOUT_EN builds the bus-wait watchdog;
//               without it BUSY waits indefinitely and timeout_err is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wmask,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_valid,
  output logic                pipe_stall,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wmask,
  input  logic                bus_ack,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                timeout_err
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_BUSY_IF  = 2'd1;
  localparam logic [1:0] S_BUSY_MEM = 2'd2;
  localparam logic [1:0] S_RESP     = 2'd3;

  logic [1:0] state;
  // Port owning the current/last transaction: 1 = MEM, 0 = IF. It doubles as
  // the round-robin history and as the selector for the RESP valid pulse.
  logic       last_grant_mem;

  logic busy;
  logic grant_mem;
  logic grant_if;
  logic tmo_hit;

  assign busy = (state == S_BUSY_IF) || (state == S_BUSY_MEM);

  // With both ports pending, MEM wins unless it was the previous owner.
  assign grant_mem = mem_req & (~if_req | ~last_grant_mem);
  assign grant_if  = if_req & ~grant_mem;

  assign if_valid   = (state == S_RESP) & ~last_grant_mem;
  assign mem_valid  = (state == S_RESP) &  last_grant_mem;
  assign pipe_stall = (if_req & ~if_valid) | (mem_req & ~mem_valid);

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 256) ? 8 : 16;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt;

  // The counter holds the number of completed ack-less busy cycles, so the
  // limit is reached on the busy cycle where it equals TIMEOUT_CYCLES-1.
  assign tmo_hit = busy & ~bus_ack & (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (!busy) begin
        tmo_cnt <= '0;
      end else if (!bus_ack) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (tmo_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      last_grant_mem <= 1'b0;
      bus_req        <= 1'b0;
      bus_we         <= 1'b0;
      bus_addr       <= '0;
      bus_wdata      <= '0;
      bus_wmask      <= '0;
      if_rdata       <= '0;
      mem_rdata      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_mem) begin
            bus_req        <= 1'b1;
            bus_we         <= mem_we;
            bus_addr       <= mem_addr;
            bus_wdata      <= mem_wdata;
            bus_wmask      <= mem_wmask;
            last_grant_mem <= 1'b1;
            state          <= S_BUSY_MEM;
          end else if (grant_if) begin
            bus_req        <= 1'b1;
            bus_we         <= 1'b0;
            bus_addr       <= if_addr;
            bus_wdata      <= '0;
            bus_wmask      <= '0;
            last_grant_mem <= 1'b0;
            state          <= S_BUSY_IF;
          end
        end
        S_BUSY_IF, S_BUSY_MEM: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            state   <= S_RESP;
            // Stores leave the port's read data untouched.
            if (!bus_we) begin
              if (last_grant_mem) begin
                mem_rdata <= bus_rdata;
              end else begin
                if_rdata <= bus_rdata;
              end
            end
          end else if (tmo_hit) begin
            // Abandoned transaction completes with zero data.
            bus_req <= 1'b0;
            state   <= S_RESP;
            if (last_grant_mem) begin
              mem_rdata <= '0;
            end else begin
              if_rdata <= '0;
            end
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. Directed scenarios
//               (reset, single fetch, waited store, simultaneous requests,
//               reset abort, optional timeout) followed by a randomized phase
//               checked against a behavioural model of requesters, memory
//               contents and the round-robin grant rule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic [63:0] if_rdata;
  logic        if_valid;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic [63:0] mem_rdata;
  logic        mem_valid;
  logic        pipe_stall;
  logic        bus_req;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wmask;
  logic        bus_ack;
  logic [63:0] bus_rdata;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(
    .ADDR_W        (64),
    .DATA_W        (64),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_valid   (if_valid),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_rdata  (mem_rdata),
    .mem_valid  (mem_valid),
    .pipe_stall (pipe_stall),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_wmask  (bus_wmask),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Randomized-phase model state
  logic [63:0] mm [8];
  logic [63:0] exp_if_rd;
  logic [63:0] exp_mem_rd;
  logic [63:0] cur_addr;
  logic [63:0] cur_wdata;
  logic [7:0]  cur_mask;
  logic        cur_we;
  int          prev_win;   // 0 = IF, 1 = MEM
  int          txn_port;   // -1 = no transaction on the bus
  int          expv;       // port expected to show valid this cycle, -1 none
  int          waitl;
  int          w;

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
    mem_addr = '0; mem_wdata = '0; mem_wmask = '0; bus_ack = 1'b0; bus_rdata = '0;

    // ---- Reset then idle ----
    step(); step();
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_timeout_err", timeout_err, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_bus_req", bus_req, 0);
      chk("idle_stall", pipe_stall, 0);
    end

    // ---- Single fetch, zero-wait ----
    if_req = 1'b1; if_addr = 64'h1000;
    #1;
    chk("f_stall_pre", pipe_stall, 1);
    step();
    chk("f_bus_req", bus_req, 1);
    chk("f_bus_addr", bus_addr, 64'h1000);
    chk("f_bus_we", bus_we, 0);
    chk("f_bus_wmask", bus_wmask, 0);
    chk("f_if_valid_early", if_valid, 0);
    bus_ack = 1'b1; bus_rdata = 64'h13;
    step();
    chk("f_if_valid", if_valid, 1);
    chk("f_if_rdata", if_rdata, 64'h13);
    chk("f_mem_valid", mem_valid, 0);
    chk("f_bus_req_drop", bus_req, 0);
    chk("f_stall_done", pipe_stall, 0);
    if_req = 1'b0; bus_ack = 1'b0;
    step();
    chk("f_if_valid_one", if_valid, 0);

    // ---- Store with 3 wait states ----
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 64'h2008;
    mem_wdata = 64'hDEADBEEF; mem_wmask = 8'h0F;
    step();
    chk("s_bus_req", bus_req, 1);
    chk("s_bus_we", bus_we, 1);
    chk("s_bus_addr", bus_addr, 64'h2008);
    chk("s_bus_wdata", bus_wdata, 64'hDEADBEEF);
    chk("s_bus_wmask", bus_wmask, 8'h0F);
    mem_addr = 64'h3000; mem_wdata = 64'h0;   // ignored while busy
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s_hold_req", bus_req, 1);
      chk("s_hold_addr", bus_addr, 64'h2008);
      chk("s_hold_wdata", bus_wdata, 64'hDEADBEEF);
      chk("s_no_valid", mem_valid, 0);
      chk("s_stall", pipe_stall, 1);
    end
    bus_ack = 1'b1; bus_rdata = 64'h5555_6666_7777_8888;
    step();
    chk("s_mem_valid", mem_valid, 1);
    chk("s_if_valid", if_valid, 0);
    chk("s_mem_rdata_kept", mem_rdata, 0);
    chk("s_bus_req_drop", bus_req, 0);
    mem_req = 1'b0; mem_we = 1'b0; bus_ack = 1'b0;
    step();

    // ---- Simultaneous requests after reset ----
    rst = 1'b1; step(); step(); rst = 1'b0;
    if_req = 1'b1; if_addr = 64'h1040;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h2100;
    #1;
    chk("b_stall0", pipe_stall, 1);
    step();
    chk("b_mem_first", bus_addr, 64'h2100);
    chk("b_bus_we", bus_we, 0);
    chk("b_stall1", pipe_stall, 1);
    bus_ack = 1'b1; bus_rdata = 64'hAAAA;
    step();
    chk("b_mem_valid", mem_valid, 1);
    chk("b_if_valid0", if_valid, 0);
    chk("b_mem_rdata", mem_rdata, 64'hAAAA);
    chk("b_stall2", pipe_stall, 1);
    mem_req = 1'b0; bus_ack = 1'b0;
    step();
    chk("b_idle_req", bus_req, 0);
    chk("b_stall3", pipe_stall, 1);
    chk("b_if_valid1", if_valid, 0);
    step();
    chk("b_if_grant", bus_req, 1);
    chk("b_if_addr", bus_addr, 64'h1040);
    bus_ack = 1'b1; bus_rdata = 64'hBBBB;
    step();
    chk("b_if_valid", if_valid, 1);
    chk("b_mem_valid1", mem_valid, 0);
    chk("b_if_rdata", if_rdata, 64'hBBBB);
    chk("b_stall4", pipe_stall, 0);
    if_req = 1'b0; bus_ack = 1'b0;
    step();

    // ---- Reset mid-transaction ----
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h2200;
    step();
    chk("r_busy", bus_req, 1);
    rst = 1'b1;
    step();
    chk("r_bus_req_drop", bus_req, 0);
    chk("r_no_valid", mem_valid, 0);
    rst = 1'b0; mem_req = 1'b0; bus_ack = 1'b1; bus_rdata = 64'hCCCC;
    step();
    chk("r_late_ack_req", bus_req, 0);
    chk("r_late_ack_valid", mem_valid, 0);
    chk("r_late_ack_rdata", mem_rdata, 0);
    bus_ack = 1'b0;
    step();
    chk("r_still_idle", mem_valid, 0);
    if_req = 1'b1; if_addr = 64'h1080;
    step();
    chk("r_fresh_grant", bus_req, 1);
    chk("r_fresh_addr", bus_addr, 64'h1080);
    bus_ack = 1'b1; bus_rdata = 64'h77;
    step();
    chk("r_fresh_valid", if_valid, 1);
    chk("r_fresh_rdata", if_rdata, 64'h77);
    if_req = 1'b0; bus_ack = 1'b0;
    step();

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    // ---- Timeout ----
    if_req = 1'b1; if_addr = 64'h1100;
    step();
    chk("t_busy1", bus_req, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t_busy_hold", bus_req, 1);
      chk("t_no_valid", if_valid, 0);
    end
    step();
    chk("t_bus_req_drop", bus_req, 0);
    chk("t_if_valid", if_valid, 1);
    chk("t_if_rdata", if_rdata, 0);
    chk("t_err_set", timeout_err, 1);
    if_req = 1'b0;
    step(); step();
    chk("t_err_sticky", timeout_err, 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t_err_cleared", timeout_err, 0);
`else
    chk("no_tmo_err", timeout_err, 0);
`endif

    // ---- Randomized phase ----
    rst = 1'b1; step(); step(); rst = 1'b0;
    for (int i = 0; i < 8; i++) mm[i] = {$urandom, $urandom};
    exp_if_rd = '0; exp_mem_rd = '0;
    prev_win = 0; txn_port = -1; expv = -1; waitl = 0; w = 0;
    cur_addr = '0; cur_wdata = '0; cur_mask = '0; cur_we = 1'b0;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      step();
      // Completion pulses and stall
      chk("rnd_if_valid", if_valid, expv == 0);
      chk("rnd_mem_valid", mem_valid, expv == 1);
      chk("rnd_stall", pipe_stall, (if_req && expv != 0) || (mem_req && expv != 1));
      if (expv == 0) begin
        chk("rnd_if_rdata", if_rdata, exp_if_rd);
        if_req = 1'b0;
      end
      if (expv == 1) begin
        chk("rnd_mem_rdata", mem_rdata, exp_mem_rd);
        mem_req = 1'b0;
      end
      expv = -1;

      // Grant observation / bus stability
      if (txn_port < 0) begin
        if (bus_req) begin
          chk("rnd_grant_has_req", if_req | mem_req, 1);
          if (if_req && mem_req) w = (prev_win == 0) ? 1 : 0;
          else w = mem_req ? 1 : 0;
          cur_addr  = (w == 1) ? mem_addr : if_addr;
          cur_we    = (w == 1) ? mem_we : 1'b0;
          cur_mask  = (w == 1) ? mem_wmask : 8'h00;
          cur_wdata = mem_wdata;
          chk("rnd_grant_addr", bus_addr, cur_addr);
          chk("rnd_grant_we", bus_we, cur_we);
          chk("rnd_grant_mask", bus_wmask, cur_mask);
          if (cur_we) chk("rnd_grant_wdata", bus_wdata, cur_wdata);
          prev_win = w;
          txn_port = w;
          waitl = $urandom_range(0, 3);
        end
      end else begin
        chk("rnd_hold_req", bus_req, 1);
        chk("rnd_hold_addr", bus_addr, cur_addr);
      end

      // Slave
      if (txn_port >= 0) begin
        if (waitl == 0) begin
          bus_ack = 1'b1;
          if (cur_we) begin
            for (int b = 0; b < 8; b++)
              if (cur_mask[b]) mm[cur_addr[5:3]][b*8 +: 8] = cur_wdata[b*8 +: 8];
            bus_rdata = {$urandom, $urandom};
          end else begin
            bus_rdata = mm[cur_addr[5:3]];
            if (txn_port == 0) exp_if_rd = bus_rdata;
            else exp_mem_rd = bus_rdata;
          end
          expv = txn_port;
          txn_port = -1;
        end else begin
          waitl--;
          bus_ack = 1'b0;
          bus_rdata = {$urandom, $urandom};
        end
      end else begin
        bus_ack = ($urandom_range(0, 3) == 0);
        bus_rdata = {$urandom, $urandom};
      end

      // Requesters raise new work only when idle
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req  = 1'b1;
        if_addr = 64'h1000 + 64'($urandom_range(0, 7) * 8);
      end
      if (!mem_req && $urandom_range(0, 2) == 0) begin
        mem_req   = 1'b1;
        mem_we    = $urandom_range(0, 1) == 1;
        mem_addr  = 64'h1000 + 64'($urandom_range(0, 7) * 8);
        mem_wdata = {$urandom, $urandom};
        mem_wmask = 8'($urandom_range(0, 255));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
